// File: rtl/pci_ram_target.sv
`default_nettype none
// ============================================================================
//  Module      : pci_ram_target
//  Description : PCI-style target that bridges the multiplexed 32-bit AD bus
//                to a synchronous single-port RAM with a 1-cycle registered
//                read latency. Provides base-address decode, the
//                IRDY#/TRDY#/DEVSEL#/STOP# handshake, byte-enabled writes,
//                single-phase I/O, a burst limit and disconnect at the top
//                of memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module pci_ram_target #(
    parameter int          AW        = 8,
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int          MAX_BURST = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_n,
    input  logic          irdy_n,
    input  logic [3:0]    c_be,
    inout  wire  [31:0]   adbus,
    output logic          trdy_n,
    output logic          devsel_n,
    output logic          stop_n,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_be,
    output logic          mem_wren,
    output logic          mem_rden,
    input  logic [31:0]   mem_rdata
);

    localparam int CW = $clog2(MAX_BURST + 1);

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_SKIP     = 3'd1;
    localparam logic [2:0] c_ST_WR       = 3'd2;
    localparam logic [2:0] c_ST_RD_FETCH = 3'd3;
    localparam logic [2:0] c_ST_RD_DATA  = 3'd4;
    localparam logic [2:0] c_ST_DISC     = 3'd5;
    localparam logic [2:0] c_ST_TURN     = 3'd6;

    localparam logic [CW-1:0] c_CNT_LAST = CW'(MAX_BURST - 1);
    localparam logic [AW-1:0] c_ADDR_TOP = '1;

    logic [2:0]    r_state;
    logic [2:0]    w_state_nxt;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] w_addr_nxt;
    logic [CW-1:0] r_cnt;
    logic          r_cmd_io;
    logic          r_frame_prev;
    logic [31:0]   r_rd_data;
    logic          r_rd_hold;
    logic [AW-1:0] r_mem_addr;
    logic [31:0]   r_mem_wdata;
    logic [3:0]    r_mem_be;
    logic          r_mem_wren;
    logic          r_mem_rden;

    logic          w_addr_phase;
    logic          w_hit;
    logic          w_cmd_ok;
    logic          w_last;
    logic          w_xfer;
    logic          w_ad_oe;
    logic [31:0]   w_rd_data;

    // Address phase is the falling edge of FRAME# seen while idle
    assign w_addr_phase = (r_state == c_ST_IDLE) && !frame_n && r_frame_prev;
    assign w_hit        = (adbus[31:AW+2] == BASE_ADDR[31:AW+2]);
    assign w_cmd_ok     = (c_be == 4'b0010) || (c_be == 4'b0011) ||
                          (c_be == 4'b0110) || (c_be == 4'b0111);
    // Top word and final burst phase both force a disconnect-with-data
    assign w_last       = (r_addr == c_ADDR_TOP) || (r_cnt == c_CNT_LAST) || r_cmd_io;
    assign w_xfer       = !irdy_n && !trdy_n;

    // Read data is taken straight from the RAM on the first RD_DATA cycle and
    // from the holding register on any initiator wait states that follow
    assign w_rd_data = r_rd_hold ? r_rd_data : mem_rdata;
    assign adbus     = w_ad_oe ? w_rd_data : 'z;

    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_be    = r_mem_be;
    assign mem_wren  = r_mem_wren;
    assign mem_rden  = r_mem_rden;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_addr_phase) begin
                    if (w_hit && w_cmd_ok) begin
                        w_state_nxt = c_be[0] ? c_ST_WR : c_ST_RD_FETCH;
                    end else begin
                        w_state_nxt = c_ST_SKIP;
                    end
                end
            end
            c_ST_SKIP: begin
                if (frame_n && irdy_n) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_WR: begin
                if (w_xfer) begin
                    if (frame_n) begin
                        w_state_nxt = c_ST_TURN;
                    end else if (!stop_n) begin
                        w_state_nxt = c_ST_DISC;
                    end
                end
            end
            c_ST_RD_FETCH: begin
                w_state_nxt = c_ST_RD_DATA;
            end
            c_ST_RD_DATA: begin
                if (w_xfer) begin
                    if (frame_n) begin
                        w_state_nxt = c_ST_TURN;
                    end else if (!stop_n) begin
                        w_state_nxt = c_ST_DISC;
                    end else begin
                        w_state_nxt = c_ST_RD_FETCH;
                    end
                end
            end
            c_ST_DISC: begin
                if (frame_n) begin
                    w_state_nxt = c_ST_TURN;
                end
            end
            c_ST_TURN: begin
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Bus handshake outputs and AD drive enable
    always_comb begin
        devsel_n = 1'b1;
        trdy_n   = 1'b1;
        stop_n   = 1'b1;
        w_ad_oe  = 1'b0;
        case (r_state)
            c_ST_WR: begin
                devsel_n = 1'b0;
                trdy_n   = 1'b0;
                stop_n   = !(w_last && !frame_n);
            end
            c_ST_RD_FETCH: begin
                devsel_n = 1'b0;
            end
            c_ST_RD_DATA: begin
                devsel_n = 1'b0;
                trdy_n   = 1'b0;
                stop_n   = !(w_last && !frame_n);
                w_ad_oe  = 1'b1;
            end
            c_ST_DISC: begin
                devsel_n = 1'b0;
                stop_n   = 1'b0;
            end
            default: begin
                devsel_n = 1'b1;
            end
        endcase
    end

    // Word address for the next data phase
    always_comb begin
        w_addr_nxt = r_addr;
        if (w_addr_phase) begin
            w_addr_nxt = adbus[AW+1:2];
        end else if (w_xfer) begin
            w_addr_nxt = r_addr + AW'(1);
        end
    end

    // Transaction context: address, phase count, command type, FRAME# history
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr       <= '0;
            r_cnt        <= '0;
            r_cmd_io     <= 1'b0;
            r_frame_prev <= 1'b1;
        end else begin
            r_frame_prev <= frame_n;
            r_addr       <= w_addr_nxt;
            if (w_addr_phase) begin
                r_cnt    <= '0;
                r_cmd_io <= !c_be[2];
            end else if (w_xfer) begin
                r_cnt    <= r_cnt + CW'(1);
            end
        end
    end

    // RAM port: write strobe follows each write transfer, read strobe covers RD_FETCH
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
            r_mem_wren  <= 1'b0;
            r_mem_rden  <= 1'b0;
        end else begin
            r_mem_wren <= (r_state == c_ST_WR) && w_xfer;
            r_mem_rden <= (w_state_nxt == c_ST_RD_FETCH);
            if ((r_state == c_ST_WR) && w_xfer) begin
                r_mem_addr  <= r_addr;
                r_mem_wdata <= adbus;
                r_mem_be    <= ~c_be;
            end else if (w_state_nxt == c_ST_RD_FETCH) begin
                r_mem_addr  <= w_addr_nxt;
            end
        end
    end

    // Capture the RAM word so it stays on AD across initiator wait states
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_data <= '0;
            r_rd_hold <= 1'b0;
        end else begin
            r_rd_hold <= (r_state == c_ST_RD_DATA) && !w_xfer;
            if (r_state == c_ST_RD_DATA) begin
                r_rd_data <= w_rd_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pci_ram_target.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pci_ram_target
//  Description : Self-checking bench for pci_ram_target. A bus initiator
//                drives directed transactions, expected RAM writes and data
//                phases are queued, and a monitor compares them as they occur.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pci_ram_target;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_n;
    logic        irdy_n;
    logic [3:0]  c_be;
    wire  [31:0] adbus;
    logic        trdy_n;
    logic        devsel_n;
    logic        stop_n;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_wren;
    logic        mem_rden;
    logic [31:0] mem_rdata;

    logic        ad_drv;
    logic [31:0] ad_out;
    assign adbus = ad_drv ? ad_out : 32'bz;

    int checks = 0;
    int errors = 0;

    typedef struct { logic [7:0] a; logic [31:0] d; logic [3:0] be; } wr_t;
    typedef struct { bit rd; logic [31:0] d; logic stp_n; } ph_t;
    wr_t wq[$];
    ph_t pq[$];

    logic [31:0] wdat [0:31];
    logic [3:0]  wbe  [0:31];

    logic [31:0] ram [0:255];
    bit          ram_init = 1'b0;

    pci_ram_target #(
        .AW(8), .BASE_ADDR(32'h1000_0000), .MAX_BURST(16)
    ) dut (
        .clk(clk), .rst(rst_n), .frame_n(frame_n), .irdy_n(irdy_n), .c_be(c_be),
        .adbus(adbus), .trdy_n(trdy_n), .devsel_n(devsel_n), .stop_n(stop_n),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_wren(mem_wren), .mem_rden(mem_rden), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input int i);
        return 32'hC0DE_0000 + i;
    endfunction

    // RAM model with 1-cycle registered read
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= pat(i);
            ram_init <= 1'b1;
        end else begin
            if (mem_wren)
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            if (mem_rden) mem_rdata <= ram[mem_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic exp_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_t e;
        e.a = a; e.d = d; e.be = be;
        wq.push_back(e);
    endtask

    task automatic exp_ph(input bit rd, input logic [31:0] d, input logic s);
        ph_t e;
        e.rd = rd; e.d = d; e.stp_n = s;
        pq.push_back(e);
    endtask

    // Monitor: RAM write strobes and completed data phases
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_wren) begin
                if (wq.size() == 0) begin
                    chk("unexpected_wr_addr", {24'd0, mem_addr}, 32'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    chk("wr_addr", {24'd0, mem_addr}, {24'd0, e.a});
                    chk("wr_data", mem_wdata, e.d);
                    chk("wr_be", {28'd0, mem_be}, {28'd0, e.be});
                end
            end
            if (!irdy_n && !trdy_n) begin
                if (pq.size() == 0) begin
                    chk("unexpected_phase", 32'd1, 32'd0);
                end else begin
                    ph_t p;
                    p = pq.pop_front();
                    chk("phase_stop_n", {31'd0, stop_n}, {31'd0, p.stp_n});
                    if (p.rd) chk("rd_data", adbus, p.d);
                end
            end
        end
    end

    task automatic drive_phase(input bit is_rd, input int ph, input int n,
                               input bit wmode, input bit waited);
        if (is_rd) begin
            ad_drv = 1'b0;
            c_be   = 4'b0000;
        end else begin
            ad_drv = 1'b1;
            ad_out = wdat[ph];
            c_be   = wbe[ph];
        end
        irdy_n  = (wmode && !waited) ? 1'b1 : 1'b0;
        frame_n = ((ph == n - 1) && !irdy_n) ? 1'b1 : 1'b0;
    endtask

    // Initiator: one transaction of up to n phases; honours STOP# and master-aborts on no DEVSEL#
    task automatic txn(input logic [3:0] cmd, input logic [31:0] addr, input int n,
                       input bit wmode, input int disc_hold, input bit miss);
        int ph, cyc, twait;
        bit xfer, stp, waited, fin, is_rd, abort;
        is_rd = !cmd[0];
        @(posedge clk); #1;
        frame_n = 1'b0; irdy_n = 1'b1; ad_drv = 1'b1; ad_out = addr; c_be = cmd;
        @(posedge clk); #1;
        ph = 0; cyc = 0; twait = 0; waited = 1'b0; fin = 1'b0; abort = 1'b0;
        drive_phase(is_rd, ph, n, wmode, waited);
        while (!fin) begin
            @(negedge clk);
            xfer = !irdy_n && !trdy_n;
            stp  = !stop_n;
            cyc++;
            if (miss) begin
                chk("miss_devsel_n", {31'd0, devsel_n}, 32'd1);
                chk("miss_ram_access", {30'd0, mem_rden, mem_wren}, 32'd0);
            end
            if (!irdy_n && trdy_n && !devsel_n) twait++;
            if (xfer && is_rd) begin
                chk("rd_wait_states", twait, 32'd1);
                twait = 0;
            end
            if (devsel_n && cyc >= 5) abort = 1'b1;
            if (cyc > 100) begin
                chk("txn_timeout", 32'd1, 32'd0);
                abort = 1'b1;
            end
            @(posedge clk); #1;
            if (abort) begin
                fin = 1'b1;
            end else if (xfer || stp) begin
                if (xfer) ph++;
                waited = 1'b0;
                if (xfer && frame_n) begin
                    fin = 1'b1;
                end else if (stp) begin
                    irdy_n = 1'b1; ad_drv = 1'b0;
                    repeat (disc_hold) begin
                        @(negedge clk);
                        chk("disc_outputs", {29'd0, devsel_n, trdy_n, stop_n}, 32'b010);
                        @(posedge clk); #1;
                    end
                    frame_n = 1'b1;
                    @(negedge clk);
                    chk("disc_outputs", {29'd0, devsel_n, trdy_n, stop_n}, 32'b010);
                    @(posedge clk); #1;
                    fin = 1'b1;
                end else begin
                    drive_phase(is_rd, ph, n, wmode, waited);
                end
            end else begin
                if (irdy_n) waited = 1'b1;
                drive_phase(is_rd, ph, n, wmode, waited);
            end
        end
        frame_n = 1'b1; irdy_n = 1'b1; ad_drv = 1'b0; c_be = 4'b0000;
        @(negedge clk);
        chk("turn_outputs", {29'd0, devsel_n, trdy_n, stop_n}, 32'b111);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; frame_n = 1'b1; irdy_n = 1'b1; c_be = 4'b0000;
        ad_drv = 1'b0; ad_out = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_handshake", {29'd0, devsel_n, trdy_n, stop_n}, 32'b111);
        chk("rst_strobes", {30'd0, mem_wren, mem_rden}, 32'd0);
        chk("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Four-phase memory write at word 4
        for (int k = 0; k < 4; k++) begin
            wdat[k] = 32'hAAAA_0000 + k; wbe[k] = 4'b0000;
            exp_wr(8'(4 + k), 32'hAAAA_0000 + k, 4'hF);
            exp_ph(1'b0, 32'd0, 1'b1);
        end
        txn(4'b0111, 32'h1000_0010, 4, 1'b0, 0, 1'b0);

        // Four-phase memory read of the same words
        for (int k = 0; k < 4; k++) exp_ph(1'b1, 32'hAAAA_0000 + k, 1'b1);
        txn(4'b0110, 32'h1000_0010, 4, 1'b0, 0, 1'b0);

        // Byte-enabled write with initiator wait states, then read back
        wdat[0] = 32'h1234_5678; wbe[0] = 4'b1100;
        wdat[1] = 32'h9ABC_DEF0; wbe[1] = 4'b0000;
        exp_wr(8'd0, 32'h1234_5678, 4'b0011); exp_ph(1'b0, 32'd0, 1'b1);
        exp_wr(8'd1, 32'h9ABC_DEF0, 4'b1111); exp_ph(1'b0, 32'd0, 1'b1);
        txn(4'b0111, 32'h1000_0000, 2, 1'b1, 0, 1'b0);
        exp_ph(1'b1, 32'hC0DE_5678, 1'b1);
        exp_ph(1'b1, 32'h9ABC_DEF0, 1'b1);
        txn(4'b0110, 32'h1000_0000, 2, 1'b0, 0, 1'b0);

        // Single-phase write: FRAME# already high on the first data phase
        wdat[0] = 32'h5555_AAAA; wbe[0] = 4'b0000;
        exp_wr(8'd9, 32'h5555_AAAA, 4'hF); exp_ph(1'b0, 32'd0, 1'b1);
        txn(4'b0111, 32'h1000_0024, 1, 1'b0, 0, 1'b0);

        // Write across the top of memory: word 255 carries STOP#
        for (int k = 0; k < 4; k++) begin
            wdat[k] = 32'hDDDD_0000 + k; wbe[k] = 4'b0000;
        end
        exp_wr(8'd254, 32'hDDDD_0000, 4'hF); exp_ph(1'b0, 32'd0, 1'b1);
        exp_wr(8'd255, 32'hDDDD_0001, 4'hF); exp_ph(1'b0, 32'd0, 1'b0);
        txn(4'b0111, 32'h1000_03F8, 4, 1'b0, 2, 1'b0);

        // I/O write disconnects after one phase; then a decode miss
        wdat[0] = 32'h0101_0202; wbe[0] = 4'b0000;
        wdat[1] = 32'h0303_0404; wbe[1] = 4'b0000;
        wdat[2] = 32'h0505_0606; wbe[2] = 4'b0000;
        exp_wr(8'd8, 32'h0101_0202, 4'hF); exp_ph(1'b0, 32'd0, 1'b0);
        txn(4'b0011, 32'h1000_0020, 3, 1'b0, 0, 1'b0);
        txn(4'b0110, 32'h2000_0000, 1, 1'b0, 0, 1'b1);

        // Long read hits the burst limit on the 16th phase
        for (int k = 0; k < 16; k++) exp_ph(1'b1, pat(16 + k), (k == 15) ? 1'b0 : 1'b1);
        txn(4'b0110, 32'h1000_0040, 20, 1'b0, 0, 1'b0);

        // Reset during the fourth phase of a write
        for (int k = 0; k < 3; k++) begin
            exp_wr(8'(40 + k), 32'hEEEE_0000 + k, 4'hF);
            exp_ph(1'b0, 32'd0, 1'b1);
        end
        @(posedge clk); #1;
        frame_n = 1'b0; irdy_n = 1'b1; ad_drv = 1'b1; ad_out = 32'h1000_00A0; c_be = 4'b0111;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            ad_out = 32'hEEEE_0000 + k; c_be = 4'b0000; irdy_n = 1'b0;
        end
        @(posedge clk); #1;
        ad_out = 32'hEEEE_0003; irdy_n = 1'b1;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_handshake", {29'd0, devsel_n, trdy_n, stop_n}, 32'b111);
        chk("midrst_strobes", {30'd0, mem_wren, mem_rden}, 32'd0);
        chk("midrst_mem_addr", {24'd0, mem_addr}, 32'd0);
        chk("midrst_mem_wdata", mem_wdata, 32'd0);
        chk("midrst_mem_be", {28'd0, mem_be}, 32'd0);
        frame_n = 1'b1; ad_drv = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) chk("midrst_ram", ram[40 + k], 32'hEEEE_0000 + k);
        chk("midrst_ram_untouched", ram[43], pat(43));

        chk("wr_queue_empty", wq.size(), 32'd0);
        chk("phase_queue_empty", pq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
